// File: rtl/floo_wormhole_demux_pkg.sv
// Shared types for the wormhole demux: lock FSM state, debug view, default flit layout.
// Instantiating code normally supplies its own flit_t; wh_flit_t is the stand-alone default.
package floo_wormhole_demux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } wh_demux_state_e;

  typedef struct packed {
    logic       last;
    logic [6:0] id;
  } wh_hdr_t;

  typedef struct packed {
    wh_hdr_t    hdr;
    logic [7:0] payload;
  } wh_flit_t;

  typedef struct packed {
    wh_demux_state_e state;
    logic            drop;
  } wh_demux_dbg_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/floo_wormhole_demux_spill.sv
// Two-entry spill register (full throughput, registered ready) or plain wire when Bypass=1.
// Output B always holds the older flit, so draining B before A keeps order.
module floo_wormhole_demux_spill #(
  parameter type T      = logic,
  parameter bit  Bypass = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  if (Bypass) begin : gen_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
  end else begin : gen_spill
    logic a_full_q, b_full_q;
    T     a_data_q, b_data_q;
    logic a_fill, a_drain, b_fill, b_drain;

    assign a_fill  = valid_i & ready_o;
    assign a_drain = a_full_q & ~b_full_q;
    assign b_fill  = a_drain & ~ready_i;
    assign b_drain = b_full_q & ready_i;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        a_full_q <= 1'b0;
        b_full_q <= 1'b0;
        a_data_q <= '0;
        b_data_q <= '0;
      end else begin
        a_full_q <= a_fill | (a_full_q & ~a_drain);
        b_full_q <= b_fill | (b_full_q & ~b_drain);
        if (a_fill) a_data_q <= data_i;
        if (b_fill) b_data_q <= a_data_q;
      end
    end

    // Ready comes only from register state, never from ready_i.
    assign ready_o = ~a_full_q | ~b_full_q;
    assign valid_o = a_full_q | b_full_q;
    assign data_o  = b_full_q ? b_data_q : a_data_q;
  end

endmodule

// File: rtl/floo_wormhole_demux.sv
// Packet-level 1-to-N wormhole fork: the head flit's sel_i picks the output until hdr.last is accepted.
// Optional FLOO_WH_DEMUX_DROP_EN: packets with out-of-range sel_i are swallowed instead of clamped to 0.
module floo_wormhole_demux
  import floo_wormhole_demux_pkg::*;
#(
  parameter int unsigned NumRoutes = 2,
  parameter bit          CutOutput = 1'b0,
  parameter type         flit_t    = floo_wormhole_demux_pkg::wh_flit_t,
  localparam int unsigned SelWidth = idx_width(NumRoutes)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  flit_t                data_i,
  input  logic [SelWidth-1:0]  sel_i,
  output logic [NumRoutes-1:0] valid_o,
  input  logic [NumRoutes-1:0] ready_i,
  output flit_t                data_o [NumRoutes],
  output logic                 locked_o,
  output logic                 drop_o,
  output wh_demux_dbg_t        dbg_o
);

  // Handshake: a flit moves on a port when valid and ready are both high at the clock edge;
  // valid is never lowered and data/sel never change before that happens.

  wh_demux_state_e       state_q, state_d;
  logic [SelWidth-1:0]   route_q, route_d;
  logic [SelWidth-1:0]   route, sel_clamped;
  logic                  sel_oor, drop_mode, hs;
  logic [NumRoutes-1:0]  stage_valid, stage_ready;

  assign sel_oor     = (32'(sel_i) >= NumRoutes);
  assign sel_clamped = sel_oor ? '0 : sel_i;
  assign route       = (state_q == LOCKED) ? route_q : sel_clamped;
  assign hs          = valid_i & ready_o;

`ifdef FLOO_WH_DEMUX_DROP_EN
  logic drop_q, drop_d;
  assign drop_mode = (state_q == LOCKED) ? drop_q : sel_oor;
`else
  assign drop_mode = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      route_q <= '0;
`ifdef FLOO_WH_DEMUX_DROP_EN
      drop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      route_q <= route_d;
`ifdef FLOO_WH_DEMUX_DROP_EN
      drop_q  <= drop_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
`ifdef FLOO_WH_DEMUX_DROP_EN
    drop_d  = drop_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (hs && !data_i.hdr.last) begin
          state_d = LOCKED;
          route_d = sel_clamped;
`ifdef FLOO_WH_DEMUX_DROP_EN
          drop_d  = sel_oor;
`endif
        end
      end
      LOCKED: begin
        if (hs && data_i.hdr.last) begin
          state_d = IDLE;
`ifdef FLOO_WH_DEMUX_DROP_EN
          drop_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A dropped flit is consumed unconditionally and never reaches a stage.
  always_comb begin
    locked_o    = (state_q == LOCKED);
    drop_o      = valid_i & drop_mode;
    ready_o     = drop_mode | stage_ready[route];
    stage_valid = '0;
    for (int unsigned i = 0; i < NumRoutes; i++) begin
      stage_valid[i] = valid_i & ~drop_mode & (route == SelWidth'(i));
    end
  end

  assign dbg_o.state = state_q;
  assign dbg_o.drop  = drop_mode;

  for (genvar i = 0; i < NumRoutes; i++) begin : gen_out
    floo_wormhole_demux_spill #(
      .T      (flit_t),
      .Bypass (!CutOutput)
    ) i_spill (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .valid_i (stage_valid[i]),
      .ready_o (stage_ready[i]),
      .data_i  (data_i),
      .valid_o (valid_o[i]),
      .ready_i (ready_i[i]),
      .data_o  (data_o[i])
    );
  end

endmodule

// File: tb/tb_floo_wormhole_demux.sv
// Bench for floo_wormhole_demux: 4-route pass-through instance (a) and 3-route registered instance (b).
// Directed flits carry hand-chosen expected output ports; a per-instance monitor checks what leaves.
module tb_floo_wormhole_demux;
  import floo_wormhole_demux_pkg::*;

  localparam int W = 2 + $bits(wh_flit_t);
`ifdef FLOO_WH_DEMUX_DROP_EN
  localparam int T5_PORT = -1;
`else
  localparam int T5_PORT = 0;
`endif

  logic clk, rst_a_n, rst_b_n;
  int   cyc;
  int   n_tests, n_fail;

  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  logic [W-1:0] act_a, act_b, want_a, want_b;

  logic          a_valid_i, a_ready_o, a_locked_o, a_drop_o;
  wh_flit_t      a_data_i;
  logic [1:0]    a_sel_i;
  logic [3:0]    a_valid_o, a_ready_i;
  wh_flit_t      a_data_o [4];
  wh_demux_dbg_t a_dbg;

  logic          b_valid_i, b_ready_o, b_locked_o, b_drop_o;
  wh_flit_t      b_data_i;
  logic [1:0]    b_sel_i;
  logic [2:0]    b_valid_o, b_ready_i;
  wh_flit_t      b_data_o [3];
  wh_demux_dbg_t b_dbg;

  floo_wormhole_demux #(.NumRoutes(4), .CutOutput(1'b0), .flit_t(wh_flit_t)) dut_a (
    .clk_i(clk), .rst_ni(rst_a_n), .valid_i(a_valid_i), .ready_o(a_ready_o), .data_i(a_data_i),
    .sel_i(a_sel_i), .valid_o(a_valid_o), .ready_i(a_ready_i), .data_o(a_data_o),
    .locked_o(a_locked_o), .drop_o(a_drop_o), .dbg_o(a_dbg)
  );

  floo_wormhole_demux #(.NumRoutes(3), .CutOutput(1'b1), .flit_t(wh_flit_t)) dut_b (
    .clk_i(clk), .rst_ni(rst_b_n), .valid_i(b_valid_i), .ready_o(b_ready_o), .data_i(b_data_i),
    .sel_i(b_sel_i), .valid_o(b_valid_o), .ready_i(b_ready_i), .data_o(b_data_o),
    .locked_o(b_locked_o), .drop_o(b_drop_o), .dbg_o(b_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic wh_flit_t mk(input logic last, input logic [7:0] pl);
    wh_flit_t f;
    f.hdr.last = last;
    f.hdr.id   = pl[6:0];
    f.payload  = pl;
    return f;
  endfunction

  // driver tasks: all start and end at posedge+1
  task automatic drive_a(input logic last, input logic [7:0] pl, input logic [1:0] sel);
    a_valid_i = 1'b1;
    a_data_i  = mk(last, pl);
    a_sel_i   = sel;
  endtask

  task automatic accept_a(input int port);
    bit got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (a_ready_o) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL a_accept_timeout: ready_o stayed 0, required 1");
    end else if (port >= 0) begin
      exp_a.push_back({2'(port), a_data_i});
    end
    @(posedge clk); #1;
    a_valid_i = 1'b0;
  endtask

  task automatic send_a(input logic last, input logic [7:0] pl, input logic [1:0] sel, input int port);
    drive_a(last, pl, sel);
    accept_a(port);
  endtask

  task automatic send_b(input logic last, input logic [7:0] pl, input logic [1:0] sel, input int port);
    bit got = 1'b0;
    b_valid_i = 1'b1;
    b_data_i  = mk(last, pl);
    b_sel_i   = sel;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (b_ready_o) begin got = 1'b1; break; end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL b_accept_timeout: ready_o stayed 0, required 1");
    end else begin
      check("b_drop_o", 32'(b_drop_o), 32'(port < 0));
      if (port < 0) check("b_drop_valid_o", 32'(b_valid_o), 0);
      else exp_b.push_back({2'(port), b_data_i});
    end
    @(posedge clk); #1;
    b_valid_i = 1'b0;
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (a_valid_o[i] && a_ready_i[i]) begin
        act_a = {i[1:0], a_data_o[i]};
        if (exp_a.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL a_unexpected: got %0h on port %0d, required no flit", act_a, i);
        end else begin
          want_a = exp_a.pop_front();
          check("a_out", 32'(act_a), 32'(want_a));
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (b_valid_o[i] && b_ready_i[i]) begin
        act_b = {i[1:0], b_data_o[i]};
        if (exp_b.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected: got %0h on port %0d, required no flit", act_b, i);
        end else begin
          want_b = exp_b.pop_front();
          check("b_out", 32'(act_b), 32'(want_b));
        end
      end
    end
  end

  initial begin
    int c0;
    n_tests = 0; n_fail = 0; cyc = 0;
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    a_valid_i = 1'b0; a_data_i = '0; a_sel_i = '0; a_ready_i = 4'hf;
    b_valid_i = 1'b0; b_data_i = '0; b_sel_i = '0; b_ready_i = 3'h7;
    repeat (2) @(posedge clk);
    #1;
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(negedge clk);
    check("rst_a_valid_o", 32'(a_valid_o), 0);
    check("rst_a_locked_o", 32'(a_locked_o), 0);
    check("rst_a_drop_o", 32'(a_drop_o), 0);
    check("rst_a_state", 32'(a_dbg.state), 32'(IDLE));
    check("rst_b_valid_o", 32'(b_valid_o), 0);
    check("rst_b_locked_o", 32'(b_locked_o), 0);
    @(posedge clk); #1;

    // 3-flit packet: sel changes after head must be ignored
    send_a(1'b0, 8'h11, 2'd2, 2);
    check("t1_locked_head", 32'(a_locked_o), 1);
    send_a(1'b0, 8'h12, 2'd1, 2);
    send_a(1'b1, 8'h13, 2'd1, 2);
    check("t1_locked_last", 32'(a_locked_o), 0);

    // back-to-back single-flit packets
    c0 = cyc;
    send_a(1'b1, 8'h21, 2'd0, 0);
    check("t2_locked_0", 32'(a_locked_o), 0);
    send_a(1'b1, 8'h22, 2'd3, 3);
    send_a(1'b1, 8'h23, 2'd1, 1);
    check("t2_locked_1", 32'(a_locked_o), 0);
    check("t2_cycles", 32'(cyc - c0), 3);

    // gap then backpressure mid-packet
    send_a(1'b0, 8'h31, 2'd3, 3);
    repeat (3) begin
      @(negedge clk);
      check("t3_gap_valid_o", 32'(a_valid_o), 0);
      check("t3_gap_locked", 32'(a_locked_o), 1);
    end
    @(posedge clk); #1;
    a_ready_i = 4'b0111;
    drive_a(1'b0, 8'h32, 2'd0);
    repeat (2) begin
      @(negedge clk);
      check("t3_bp_ready_o", 32'(a_ready_o), 0);
      check("t3_bp_valid_o", 32'(a_valid_o), 32'h8);
      @(posedge clk); #1;
    end
    a_ready_i = 4'hf;
    accept_a(3);
    send_a(1'b1, 8'h33, 2'd2, 3);
    check("t3_locked_last", 32'(a_locked_o), 0);

    // registered outputs: latency 1, one flit per cycle
    c0 = cyc;
    fork
      begin
        for (int k = 0; k < 8; k++) send_b(k == 7, 8'h40 + 8'(k), 2'd1, 1);
      end
      begin
        @(negedge clk);
        check("t4_lat_in_cycle", 32'(b_valid_o), 0);
        @(negedge clk);
        check("t4_lat_next_cycle", 32'(b_valid_o), 32'h2);
      end
    join
    check("t4_cycles", 32'(cyc - c0), 8);
    repeat (3) @(posedge clk);
    #1;

    // ready_o comes from stage state only
    b_ready_i = 3'b101;
    fork
      send_b(1'b0, 8'h48, 2'd1, 1);
      begin
        @(negedge clk);
        check("t4_ready_hi_indep", 32'(b_ready_o), 1);
      end
    join
    send_b(1'b1, 8'h49, 2'd1, 1);
    @(negedge clk);
    check("t4_ready_full", 32'(b_ready_o), 0);
    @(posedge clk); #1;
    b_ready_i = 3'b111;
    @(negedge clk);
    check("t4_ready_lo_indep", 32'(b_ready_o), 0);
    repeat (4) @(posedge clk);
    #1;

    // out-of-range select on 3 routes
    send_b(1'b0, 8'h51, 2'd3, T5_PORT);
    check("t5_locked_head", 32'(b_locked_o), 1);
    send_b(1'b1, 8'h52, 2'd3, T5_PORT);
    check("t5_locked_last", 32'(b_locked_o), 0);
    repeat (3) @(posedge clk);
    #1;

    // reset mid-packet discards registered flits
    b_ready_i = 3'b000;
    send_b(1'b0, 8'h61, 2'd2, 2);
    @(negedge clk);
    check("t6_held_valid_o", 32'(b_valid_o), 32'h4);
    @(posedge clk); #1;
    rst_b_n = 1'b0;
    @(posedge clk); #1;
    rst_b_n = 1'b1;
    exp_b.delete();
    @(negedge clk);
    check("t6_rst_valid_o", 32'(b_valid_o), 0);
    check("t6_rst_locked", 32'(b_locked_o), 0);
    @(posedge clk); #1;
    b_ready_i = 3'b111;
    send_b(1'b0, 8'h62, 2'd0, 0);
    check("t6_new_head_locked", 32'(b_locked_o), 1);
    send_b(1'b1, 8'h63, 2'd2, 0);
    check("t6_locked_last", 32'(b_locked_o), 0);

    repeat (4) @(posedge clk);
    #1;
    check("a_queue_empty", 32'(exp_a.size()), 0);
    check("b_queue_empty", 32'(exp_b.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
